fwd_hazard_scoreboard: RTL and testbench
========================================

// Module: fwd_hazard_scoreboard
// PURPOSE
// - Parametrised forwarding and load-use hazard unit for the N-deep pipeline.
// - Tracks in-flight producers after EX in a shift-register scoreboard.
// - Drives per-operand EX forward selects (youngest wins).
// - Runs a counter-based stall FSM that holds IF/ID until a load result is forwardable.
// - Sits beside the hazard/control logic; bypass muxes in EX use fwd_sel.
// PARAMETERS
// - NSRC      2        source operands per instruction (rs, rt, ...)
// - DEPTH     3        tracked stages after EX; entry 0 = MEM, entry DEPTH-1 = oldest
// - REGW      5        register index width
// - LOAD_RDY  1        first entry index whose load data is forwardable (1 = WB)
// - SELW      $clog2(DEPTH+1)  forward select width
// - CNTW      $clog2(LOAD_RDY+2) stall counter width
// PORTS
// - CLK        in   1          clock, all state on rising edge
// - nRST       in   1          synchronous active-low reset
// - advance    in   1          pipeline moves this cycle (0 = global freeze, e.g. dcache miss)
// - flush      in   1          squash ID and EX instructions (branch/jump redirect)
// - ex_valid   in   1          EX holds a real instruction
// - ex_regwr   in   1          EX instruction writes a register
// - ex_load    in   1          EX instruction is a load
// - ex_rd      in   REGW       EX destination register
// - ex_src     in   NSRC*REGW  EX source registers, operand i at [i*REGW +: REGW]
// - id_valid   in   1          ID holds a real instruction
// - id_src     in   NSRC*REGW  ID source registers
// - fwd_sel    out  NSRC*SELW  per operand: 0 = regfile, k+1 = entry k
// - stall_id   out  1          hold PC and IF/ID, insert bubble into EX
// - fwd_err    out  1          sticky: EX consumed an unready load result
// BEHAVIOUR
// - Reset (nRST=0 at edge): all entries invalid; cnt=0; state IDLE; fwd_err=0.
//   Hence fwd_sel=0 and stall_id=0 during and after reset.
// - Scoreboard entry = {valid, regwr, load, rd}.
//   - On advance: entry k+1 <= entry k; entry 0 <= EX fields.
//   - EX fields enter as invalid if flush | ~ex_valid. Oldest entry drops off.
//   - On ~advance: entries hold.
// - Match(k, s) = valid & regwr & rd==s & s!=0. Register 0 never forwards or stalls.
// - fwd_sel[i] (combinational): smallest k with Match(k, ex_src[i]) gives k+1; none gives 0.
// - Load-use requirement:
//   - req(k) = LOAD_RDY-k-1 for a load match on entry k, with k=-1 meaning the EX instruction.
//   - need = max over all id_src and matches, floored at 0; need=0 if ~id_valid.
// - Stall FSM:
//   - IDLE:
//     - stall_id = (need>0) & ~flush.
//     - If advance & need>1 & ~flush: cnt <= need-1, go STALL.
//     - If advance & need==1: stay IDLE (one cycle only).
//   - STALL:
//     - stall_id = 1.
//     - On advance: cnt <= cnt-1; when cnt reaches 1, go IDLE.
//     - ~advance: hold cnt.
//   - flush in any state: stall_id=0 that cycle, cnt <= 0, go IDLE. Flush beats stall.
// - ~advance (freeze): FSM, counter and scoreboard all hold. stall_id keeps its current value.
// - fwd_err: set when advance & ex_valid & the winning match for any ex_src is a load with k<LOAD_RDY. Cleared only by reset.
// - Latency: fwd_sel and stall_id are combinational from inputs plus state, same cycle. Scoreboard updates one cycle after advance.
// - Same rd in several entries: the youngest wins, never an older one.
// STRUCTURE
// - cpu_types_pkg additions:
//   - regbits_t (REGW);
//   - fwd_entry_t struct {valid, regwr, load, rd};
//   - hz_state_t enum {HZ_IDLE, HZ_STALL}.
// - Sub-module fwd_match_prio: one source vs DEPTH entries, returns sel and hit-is-unready-load.
//   - Instantiated NSRC times for EX and NSRC times for ID.
// - Top holds the scoreboard array, the FSM/counter and the fwd_err flop.
// TESTING
// 1. ALU chain, rd=5 in EX then MEM, ex_src0=5 -> fwd_sel0=1. One cycle later with no rewrite -> 2.
// 2. Priority: entry0 rd=7, entry1 rd=7, ex_src1=7 -> fwd_sel1=1, not 2. Source 0 with matches -> sel 0.
// 3. Load-use, LOAD_RDY=1: lw r3 in EX, id_src0=3 -> stall_id=1 for 1 cycle. Then consumer in EX gets fwd_sel0=2; fwd_err=0.
// 4. LOAD_RDY=2, DEPTH=4: lw r9 in EX, id uses r9 -> stall_id high exactly 2 advancing cycles. Insert advance=0 for 3 cycles mid-stall -> stall extends to 5 cycles, state holds.
// 5. Flush during STALL -> stall_id=0 the same cycle, next cycle IDLE, cnt=0. Squashed EX load never forwards.
// 6. nRST=0 mid-STALL with full scoreboard -> next cycle fwd_sel=0, stall_id=0, fwd_err=0. Force the unready case (advance, ex load-match at entry 0) -> fwd_err=1 until reset.

Source files
------------

// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared types for the forwarding / load-use hazard unit: register index,
// scoreboard entry layout, stall FSM states and the entry match rule.
package fwd_hazard_scoreboard_pkg;

    localparam int REG_BITS = 5;

    typedef logic [REG_BITS-1:0] regbits_t;

    typedef struct packed {
        logic     valid;
        logic     regwr;
        logic     load;
        regbits_t rd;
    } fwd_entry_t;

    typedef enum logic {
        HZ_IDLE,
        HZ_STALL
    } hz_state_t;

    // Register 0 is hardwired, so it never forwards and never stalls.
    function automatic logic ent_match(input fwd_entry_t e, input regbits_t src);
        return e.valid & e.regwr & (e.rd == src) & (src != '0);
    endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_if.sv
// Pipeline-side bundle of the hazard unit: EX/ID operand info in,
// forward selects, ID stall and sticky error flag out.
interface fwd_hazard_scoreboard_if #(
    parameter int NSRC = 2,
    parameter int REGW = 5,
    parameter int SELW = 2
);
    logic                 advance;
    logic                 flush;
    logic                 ex_valid;
    logic                 ex_regwr;
    logic                 ex_load;
    logic [REGW-1:0]      ex_rd;
    logic [NSRC*REGW-1:0] ex_src;
    logic                 id_valid;
    logic [NSRC*REGW-1:0] id_src;
    logic [NSRC*SELW-1:0] fwd_sel;
    logic                 stall_id;
    logic                 fwd_err;

    modport master (
        output advance, flush, ex_valid, ex_regwr, ex_load, ex_rd, ex_src,
               id_valid, id_src,
        input  fwd_sel, stall_id, fwd_err
    );

    modport slave (
        input  advance, flush, ex_valid, ex_regwr, ex_load, ex_rd, ex_src,
               id_valid, id_src,
        output fwd_sel, stall_id, fwd_err
    );
endinterface

// File: rtl/fwd_hazard_scoreboard_match.sv
// One source register against all scoreboard entries: youngest-match forward
// select, whether that winner is a not-yet-forwardable load, and the load wait.
module fwd_match_prio
    import fwd_hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = 1,
    parameter int SELW     = $clog2(DEPTH + 1),
    parameter int CNTW     = $clog2(LOAD_RDY + 2)
) (
    input  regbits_t                 src,
    input  fwd_entry_t [DEPTH-1:0]   entries,
    output logic [SELW-1:0]          sel,
    output logic                     unready,
    output logic [CNTW-1:0]          req
);

    // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        sel     = '0;
        unready = 1'b0;
        req     = '0;
        // Walk oldest to youngest so the youngest match overwrites; the youngest
        // load also carries the largest remaining wait.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent_match(entries[k], src)) begin
                sel     = SELW'(k + 1);
                unready = entries[k].load & (k < LOAD_RDY);
                if (entries[k].load)
                    req = (k < LOAD_RDY - 1) ? CNTW'(LOAD_RDY - k - 1) : '0;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and load-use hazard unit: shift-register scoreboard of producers
// past EX, per-operand bypass selects and a counter-based IF/ID stall FSM.
module fwd_hazard_scoreboard
    import fwd_hazard_scoreboard_pkg::*;
#(
    parameter int NSRC     = 2,
    parameter int DEPTH    = 3,
    parameter int REGW     = REG_BITS,
    parameter int LOAD_RDY = 1,
    parameter int SELW     = $clog2(DEPTH + 1),
    parameter int CNTW     = $clog2(LOAD_RDY + 2)
) (
    input logic                    CLK,
    input logic                    nRST,
    fwd_hazard_scoreboard_if.slave hz
);

    fwd_entry_t [DEPTH-1:0]        sb;
    fwd_entry_t                    ex_ent;
    hz_state_t                     state, state_nx;
    logic [CNTW-1:0]               cnt, cnt_nx, need;
    logic                          err_q;
    logic [NSRC-1:0]               ex_unready, id_ex_hit;
    logic [NSRC-1:0][CNTW-1:0]     id_req, ex_req_unused;
    logic [NSRC-1:0][SELW-1:0]     id_sel_unused;
    logic [NSRC-1:0]               id_unready_unused;

    assign ex_ent = '{valid: hz.ex_valid & ~hz.flush, regwr: hz.ex_regwr,
                      load: hz.ex_load, rd: hz.ex_rd};

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fwd_match_prio #(.DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY), .SELW(SELW), .CNTW(CNTW)) u_ex (
            .src     (hz.ex_src[i*REGW +: REGW]),
            .entries (sb),
            .sel     (hz.fwd_sel[i*SELW +: SELW]),
            .unready (ex_unready[i]),
            .req     (ex_req_unused[i])
        );
        fwd_match_prio #(.DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY), .SELW(SELW), .CNTW(CNTW)) u_id (
            .src     (hz.id_src[i*REGW +: REGW]),
            .entries (sb),
            .sel     (id_sel_unused[i]),
            .unready (id_unready_unused[i]),
            .req     (id_req[i])
        );
        // A load still in EX is the furthest from forwardable (k = -1).
        assign id_ex_hit[i] = ent_match(ex_ent, hz.id_src[i*REGW +: REGW]) & hz.ex_load;
    end

    always_comb begin
        need = '0;
        if (hz.id_valid) begin
            for (int i = 0; i < NSRC; i++) begin
                if (id_ex_hit[i] && CNTW'(LOAD_RDY) > need) need = CNTW'(LOAD_RDY);
                if (id_req[i] > need) need = id_req[i];
            end
        end
    end

    // NOTE: the scoreboard is a handful of flops, not a RAM, so clearing it whole keeps payload bits defined after reset.
    // NOTE: sequential state uses non-blocking assignments so each entry shifts from its pre-edge neighbour.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            sb <= '0;
        end else if (hz.advance) begin
            sb[0] <= ex_ent;
            for (int k = 1; k < DEPTH; k++) sb[k] <= sb[k-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= HZ_IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (hz.advance & hz.ex_valid & (|ex_unready)) err_q <= 1'b1;
        end
    end

    // A redirect cancels any stall outright; a freeze holds state and count.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (hz.flush) begin
            state_nx = HZ_IDLE;
            cnt_nx   = '0;
        end else if (hz.advance) begin
            case (state)
                HZ_IDLE: begin
                    if (need > CNTW'(1)) begin
                        state_nx = HZ_STALL;
                        cnt_nx   = need - CNTW'(1);
                    end
                end
                HZ_STALL: begin
                    cnt_nx = cnt - CNTW'(1);
                    if (cnt <= CNTW'(1)) state_nx = HZ_IDLE;
                end
                default: state_nx = HZ_IDLE;
            endcase
        end
    end

    always_comb begin
        hz.stall_id = 1'b0;
        if (!hz.flush) hz.stall_id = (state == HZ_STALL) || (need != '0);
    end

    assign hz.fwd_err = err_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Scoreboard bench: stimulus pushes expected outputs from a queue-based model,
// a negedge monitor pops and compares them against the hazard unit.
module tb_fwd_hazard_scoreboard;

    localparam int NSRC     = 2;
    localparam int DEPTH    = 4;
    localparam int REGW     = 5;
    localparam int LOAD_RDY = 2;
    localparam int SELW     = $clog2(DEPTH + 1);

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    fwd_hazard_scoreboard_if #(.NSRC(NSRC), .REGW(REGW), .SELW(SELW)) hz ();

    fwd_hazard_scoreboard #(
        .NSRC(NSRC), .DEPTH(DEPTH), .REGW(REGW), .LOAD_RDY(LOAD_RDY)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .hz   (hz)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit nrst, adv, fl, exv, exwr, exld;
        int exrd, exs0, exs1;
        bit idv;
        int ids0, ids1;
    } stim_t;

    typedef struct {
        logic [NSRC*SELW-1:0] sel;
        bit                   stall;
        bit                   err;
    } exp_t;

    typedef struct {
        bit v, wr, ld;
        int rd;
    } ment_t;

    exp_t  exp_q[$];
    ment_t m_sb[$];   // index 0 = youngest producer past EX
    int    m_left;    // stall cycles still owed after the current one
    bit    m_err;
    stim_t cur;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hit(input ment_t e, input int s);
        return e.v && e.wr && e.rd == s && s != 0;
    endfunction

    function automatic int model_sel(input int s);
        foreach (m_sb[k]) if (hit(m_sb[k], s)) return k + 1;
        return 0;
    endfunction

    function automatic bit model_unready(input int s);
        foreach (m_sb[k]) if (hit(m_sb[k], s)) return m_sb[k].ld && k < LOAD_RDY;
        return 0;
    endfunction

    function automatic int need_one(input stim_t s, input int src);
        int n = 0;
        if (s.exv && s.exwr && s.exld && s.exrd == src && src != 0) n = LOAD_RDY;
        foreach (m_sb[k])
            if (hit(m_sb[k], src) && m_sb[k].ld && LOAD_RDY - k - 1 > n) n = LOAD_RDY - k - 1;
        return n;
    endfunction

    function automatic int model_need(input stim_t s);
        int a, b;
        if (!s.idv) return 0;
        a = need_one(s, s.ids0);
        b = need_one(s, s.ids1);
        return (a > b) ? a : b;
    endfunction

    function automatic void model_edge(input stim_t s);
        int n;
        ment_t e;
        if (!s.nrst) begin
            m_sb.delete();
            for (int k = 0; k < DEPTH; k++) m_sb.push_back('{0, 0, 0, 0});
            m_left = 0;
            m_err  = 0;
            return;
        end
        if (s.fl) begin
            m_left = 0;
        end else if (s.adv) begin
            n = model_need(s);
            if (m_left > 0) m_left--;
            else if (n > 1) m_left = n - 1;
        end
        if (s.adv) begin
            if (s.exv && (model_unready(s.exs0) || model_unready(s.exs1))) m_err = 1;
            e = '{s.exv && !s.fl, s.exwr, s.exld, s.exrd};
            m_sb.push_front(e);
            void'(m_sb.pop_back());
        end
    endfunction

    function automatic exp_t model_expect(input stim_t s);
        exp_t e;
        e.sel   = {SELW'(model_sel(s.exs1)), SELW'(model_sel(s.exs0))};
        e.stall = !s.fl && (m_left > 0 || model_need(s) > 0);
        e.err   = m_err;
        return e;
    endfunction

    task automatic drive_bus(input stim_t s);
        nRST        = s.nrst;
        hz.advance  = s.adv;
        hz.flush    = s.fl;
        hz.ex_valid = s.exv;
        hz.ex_regwr = s.exwr;
        hz.ex_load  = s.exld;
        hz.ex_rd    = REGW'(s.exrd);
        hz.ex_src   = {REGW'(s.exs1), REGW'(s.exs0)};
        hz.id_valid = s.idv;
        hz.id_src   = {REGW'(s.ids1), REGW'(s.ids0)};
    endtask

    task automatic apply(input stim_t s);
        @(posedge CLK);
        model_edge(cur);
        #1;
        cur = s;
        drive_bus(s);
        exp_q.push_back(model_expect(s));
    endtask

    function automatic stim_t mk(input bit adv, fl, exv, exwr, exld, input int exrd, exs0, exs1,
                                 input bit idv, input int ids0, ids1);
        stim_t s;
        s = '{1, adv, fl, exv, exwr, exld, exrd, exs0, exs1, idv, ids0, ids1};
        return s;
    endfunction

    function automatic stim_t mk_rst();
        stim_t s;
        s = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        return s;
    endfunction

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("fwd_sel", 32'(hz.fwd_sel), 32'(e.sel));
            check("stall_id", 32'(hz.stall_id), 32'(e.stall));
            check("fwd_err", 32'(hz.fwd_err), 32'(e.err));
        end
    end

    initial begin
        stim_t s;
        cur = mk_rst();
        drive_bus(cur);
        apply(mk_rst());
        apply(mk_rst());
        // ALU chain r5: MEM forward then WB forward
        apply(mk(1, 0, 1, 1, 0, 5, 0, 0, 0, 0, 0));
        apply(mk(1, 0, 1, 1, 0, 6, 5, 0, 0, 0, 0));
        apply(mk(1, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0));
        // Two writers of r7: youngest wins; source r0 never forwards
        apply(mk(1, 0, 1, 1, 0, 7, 0, 0, 0, 0, 0));
        apply(mk(1, 0, 1, 1, 0, 7, 0, 0, 0, 0, 0));
        apply(mk(1, 0, 1, 0, 0, 0, 0, 7, 0, 0, 0));
        apply(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        // Load-use on r9 with a three-cycle freeze mid-stall
        apply(mk(1, 0, 1, 1, 1, 9, 0, 0, 1, 9, 0));
        for (int i = 0; i < 3; i++) apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0));
        apply(mk(1, 0, 1, 1, 0, 4, 9, 0, 0, 0, 0));
        // Flush during STALL; the squashed EX load on r10 must never forward
        apply(mk(1, 0, 1, 1, 1, 9, 0, 0, 1, 0, 9));
        apply(mk(1, 1, 1, 1, 1, 10, 0, 0, 1, 0, 9));
        apply(mk(1, 0, 1, 0, 0, 0, 10, 10, 0, 0, 0));
        // Unready load consumed straight out of MEM sets the sticky error
        apply(mk(1, 0, 1, 1, 1, 3, 0, 0, 0, 0, 0));
        apply(mk(1, 0, 1, 1, 0, 8, 3, 0, 0, 0, 0));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Reset mid-STALL with a full scoreboard
        apply(mk(1, 0, 1, 1, 1, 2, 0, 0, 0, 0, 0));
        apply(mk(1, 0, 1, 1, 1, 11, 0, 0, 1, 11, 0));
        apply(mk_rst());
        apply(mk(1, 0, 0, 0, 0, 0, 11, 2, 0, 0, 0));
        // Randomised traffic over a small register window for frequent hits
        for (int n = 0; n < 800; n++) begin
            s.nrst = ($urandom_range(0, 199) != 0);
            s.adv  = ($urandom_range(0, 9) < 8);
            s.fl   = s.adv && ($urandom_range(0, 9) == 0);
            s.exv  = ($urandom_range(0, 9) < 8);
            s.exwr = ($urandom_range(0, 3) != 0);
            s.exld = s.exwr && ($urandom_range(0, 2) == 0);
            s.exrd = $urandom_range(0, 7);
            s.exs0 = $urandom_range(0, 7);
            s.exs1 = $urandom_range(0, 7);
            s.idv  = ($urandom_range(0, 4) != 0);
            s.ids0 = $urandom_range(0, 7);
            s.ids1 = $urandom_range(0, 7);
            if (!s.nrst) s = mk_rst();
            apply(s);
        end
        repeat (2) @(negedge CLK);
        check("drain_q", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
